// File: rtl/sd_spi_byte_engine.sv
// sd_spi_byte_engine: byte-wide SPI master, mode 0, for the SD-card socket.
// Shifts one byte out on mosi (MSB first) while shifting one byte in from miso.
// Each transfer ends with a one-clk done pulse that clears the CPU-visible busy
// flag. Chip select is a plain software-written bit.
// Optional build macro: SD_SPI_MISO_SYNC_EN adds a 2-flop synchronizer on miso.
module sd_spi_byte_engine #(
  parameter int unsigned SLOW_DIV = 63,  // init-rate sclk half-period, clk cycles
  parameter int unsigned FAST_DIV = 4,   // data-rate sclk half-period, clk cycles
  parameter bit          CS_IDLE  = 1'b1 // cs_n level after reset
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  input  logic       fast,
  input  logic       cs_wr,
  input  logic       cs_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam logic [7:0] SLOW_DIV8 = 8'(SLOW_DIV);
  localparam logic [7:0] FAST_DIV8 = 8'(FAST_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] half_div_reg;   // divisor latched at transfer start
  logic [7:0] half_cnt_reg;   // counts down the current sclk half-period
  logic [2:0] bit_cnt_reg;    // index of the bit currently on the wire
  logic [7:0] tx_reg;         // transmit shifter, mosi bit taken from the top
  logic [7:0] rx_reg;         // receive shifter, miso enters at the bottom
  logic       miso_s;         // miso as seen by the sampling logic
  logic [7:0] sel_div;
  logic       half_zero;

  assign sel_div   = fast ? FAST_DIV8 : SLOW_DIV8;
  assign half_zero = (half_cnt_reg == 8'd0);

`ifdef SD_SPI_MISO_SYNC_EN
  logic [1:0] miso_sync_reg;

  // Two-flop synchronizer; the sample point stays at the LOW->HIGH transition,
  // so the captured bit is miso as it was two clocks earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      miso_sync_reg <= 2'b11;
    end else begin
      miso_sync_reg <= {miso_sync_reg[0], miso};
    end
  end

  assign miso_s = miso_sync_reg[1];
`else
  assign miso_s = miso;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: each half-period ends when the countdown reaches zero.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (wr_stb) state_next = LOW;
      LOW:  if (half_zero) state_next = HIGH;
      HIGH: begin
        if (half_zero) begin
          state_next = (bit_cnt_reg == 3'd7) ? DONE : LOW;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs, advanced alongside the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_div_reg <= 8'd0;
      half_cnt_reg <= 8'd0;
      bit_cnt_reg  <= 3'd0;
      tx_reg       <= 8'd0;
      rx_reg       <= 8'd0;
      rd_data      <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      sclk         <= 1'b0;
      mosi         <= 1'b1;
      cs_n         <= CS_IDLE;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Chip select is only writable between transfers; a simultaneous
          // start sees the new level from the very first sclk edge.
          if (cs_wr) cs_n <= cs_data;
          if (wr_stb) begin
            tx_reg       <= wr_data;
            mosi         <= wr_data[7];
            half_div_reg <= sel_div;
            half_cnt_reg <= sel_div - 8'd1;
            bit_cnt_reg  <= 3'd0;
            busy         <= 1'b1;
          end
        end
        LOW: begin
          if (half_zero) begin
            sclk         <= 1'b1;
            rx_reg       <= {rx_reg[6:0], miso_s};
            half_cnt_reg <= half_div_reg - 8'd1;
          end else begin
            half_cnt_reg <= half_cnt_reg - 8'd1;
          end
        end
        HIGH: begin
          if (half_zero) begin
            sclk <= 1'b0;
            if (bit_cnt_reg != 3'd7) begin
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              tx_reg       <= {tx_reg[6:0], 1'b0};
              mosi         <= tx_reg[6];
              half_cnt_reg <= half_div_reg - 8'd1;
            end
          end else begin
            half_cnt_reg <= half_cnt_reg - 8'd1;
          end
        end
        DONE: begin
          rd_data <= rx_reg;
          done    <= 1'b1;
          busy    <= 1'b0;
          mosi    <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Testbench for sd_spi_byte_engine: directed transfers, scoreboard of expected
// bytes/timing checked by an independent monitor on done and sclk edges.
module tb_sd_spi_byte_engine;

  localparam int SLOW = 63;
  localparam int FAST = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       fast;
  logic       cs_wr;
  logic       cs_data;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       loop_en;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] rd;
    logic [7:0] tx;
    int         start;
    int         div;
  } exp_t;

  exp_t sb[$];

  assign miso = loop_en ? mosi : 1'b0;

  sd_spi_byte_engine #(.SLOW_DIV(SLOW), .FAST_DIV(FAST), .CS_IDLE(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_stb  (wr_stb),
    .wr_data (wr_data),
    .fast    (fast),
    .cs_wr   (cs_wr),
    .cs_data (cs_data),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  // Edge index: at a negedge, cyc equals the number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: checks sclk edge timing, collects mosi bits, pops on done.
  logic [7:0] mbits = 8'h00;
  int         edges = 0;
  logic       sclk_prev = 1'b0;
  logic       done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      edges     = 0;
      mbits     = 8'h00;
      sclk_prev = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (sclk && !sclk_prev) begin
        chk("sclk_in_transfer", int'(sb.size() > 0), 1);
        if (sb.size() > 0)
          chk("sclk_rise_cyc", cyc, sb[0].start + sb[0].div + 2 * sb[0].div * edges);
        mbits = {mbits[6:0], mosi};
        edges++;
      end
      if (done) begin
        chk("done_width", int'(done_prev), 0);
        chk("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rd_data", int'(rd_data), int'(e.rd));
          chk("done_cyc", cyc, e.start + 16 * e.div + 1);
          chk("mosi_bits", int'(mbits), int'(e.tx));
          chk("sclk_edges", edges, 8);
          chk("busy_at_done", int'(busy), 0);
          chk("mosi_idle", int'(mosi), 1);
          chk("sclk_idle", int'(sclk), 0);
        end
        edges = 0;
        mbits = 8'h00;
      end
      sclk_prev = sclk;
      done_prev = done;
    end
  end

  // Start a transfer; expectation pushed at issue time.
  task automatic issue(input logic [7:0] d, input logic f, input logic [7:0] exp_rd);
    exp_t e;
    @(negedge clk);
    wr_data = d;
    fast    = f;
    wr_stb  = 1'b1;
    e.rd    = exp_rd;
    e.tx    = d;
    e.start = cyc + 1;
    e.div   = f ? FAST : SLOW;
    sb.push_back(e);
    @(negedge clk);
    wr_stb = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("transfer_timeout", int'(sb.size() == 0), 1);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic write_cs(input logic v);
    @(negedge clk);
    cs_data = v;
    cs_wr   = 1'b1;
    @(negedge clk);
    cs_wr = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    wr_stb  = 1'b0;
    wr_data = 8'h00;
    fast    = 1'b0;
    cs_wr   = 1'b0;
    cs_data = 1'b1;
    loop_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 1);
    chk("rst_cs_n", int'(cs_n), 1);

    // Fast loopback of A5 with cs asserted.
    write_cs(1'b0);
    chk("cs_n_low", int'(cs_n), 0);
    issue(8'hA5, 1'b1, 8'hA5);
    wait_done();
    chk("rd_data_hold_A5", int'(rd_data), 8'hA5);

    // Slow rate, miso tied low.
    loop_en = 1'b0;
    issue(8'hFF, 1'b0, 8'h00);
    wait_done();
    loop_en = 1'b1;

    // Second strobe mid-transfer must be ignored.
    issue(8'hC3, 1'b1, 8'hC3);
    repeat (8) @(negedge clk);
    wr_data = 8'h3C;
    wr_stb  = 1'b1;
    @(negedge clk);
    wr_stb = 1'b0;
    wait_done();
    repeat (80) @(negedge clk);
    chk("no_extra_done_busy", int'(busy), 0);

    // Reset at clk 20 of a transfer.
    issue(8'h96, 1'b1, 8'h96);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_mosi", int'(mosi), 1);
    chk("abort_cs_n", int'(cs_n), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_rd_data", int'(rd_data), 0);
    reset = 1'b0;
    @(negedge clk);
    issue(8'h5A, 1'b1, 8'h5A);
    wait_done();

    // cs writes ignored while busy, honoured once idle.
    write_cs(1'b0);
    issue(8'h81, 1'b1, 8'h81);
    write_cs(1'b1);
    chk("cs_n_busy_hold", int'(cs_n), 0);
    wait_done();
    write_cs(1'b1);
    chk("cs_n_after_done", int'(cs_n), 1);

    // Back-to-back: strobe on the clk right after done.
    issue(8'h42, 1'b1, 8'h42);
    while (!done && busy) @(negedge clk);
    issue(8'h24, 1'b1, 8'h24);
    wait_done();
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
